// File: rtl/decoder_nx2n_scan.sv
// decoder_nx2n_scan
//   Registered SEL_W-to-2**SEL_W one-hot (or one-cold) strobe decoder with a
//   valid/ready command port.
//   - DIRECT mode latches a single decoded line.
//   - SCAN mode walks the strobe across every output, starting at a given index.
//     Each line is held for DWELL cycles, and the index wraps from OUT_W-1 to 0.
//
// Optional feature macro: DECODER_ABORT_EN
//   When defined, the abort input exists and can end a running scan early.
//
// Handshake: a command is accepted on a rising edge where in_valid & in_ready.
//   in_ready = en & ~busy & ~rst, and is purely combinational. When in_ready
//   is low, in_valid is ignored and the command is not queued.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         global enable; 0 freezes all state, counters and out
//   in_valid   command valid
//   in_ready   command can be accepted this cycle
//   mode       0 = DIRECT, 1 = SCAN (sampled on accept)
//   sel        DIRECT: line to assert; SCAN: start index (sampled on accept)
//   abort      (DECODER_ABORT_EN only) ends an active scan
//   out        registered strobes (OUT_W wide)
//   out_valid  1-cycle pulse whenever out takes a new active line
//   busy       high while scanning
//   scan_done  1-cycle pulse when a scan ends (completion or abort)
//   state_dbg  current FSM state (0 IDLE, 1 DIRECT, 2 SCAN)
module decoder_nx2n_scan #(
  parameter int SEL_W      = 3,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
`ifdef DECODER_ABORT_EN
  input  logic                abort,
`endif
  output logic [2**SEL_W-1:0] out,
  output logic                out_valid,
  output logic                busy,
  output logic                scan_done,
  output logic [1:0]          state_dbg
);

  localparam int OUT_W = 2**SEL_W;
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [OUT_W-1:0] INACTIVE   = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
  localparam logic [SEL_W-1:0] LAST_STEP  = {SEL_W{1'b1}};
  localparam logic [DW_W-1:0]  LAST_DWELL = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [SEL_W-1:0]  step_q, step_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              scan_done_q, scan_done_d;
  logic              accept;
  logic              abort_req;

`ifdef DECODER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Output polarity is applied only here. The index and counters always
  // work on plain line numbers.
  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] line);
    logic [OUT_W-1:0] v;
    v       = '0;
    v[line] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  assign busy      = (state_q == ST_SCAN);
  assign in_ready  = en & ~busy & ~rst;
  assign accept    = in_valid & in_ready;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign scan_done = scan_done_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    scan_done_d = 1'b0;
    // With en low nothing advances, and the pulse outputs drop to 0.
    if (en) begin
      case (state_q)
        ST_IDLE, ST_DIRECT: begin
          if (accept) begin
            idx_d       = sel;
            out_d       = decode(sel);
            out_valid_d = 1'b1;
            step_d      = '0;
            dwell_d     = '0;
            state_d     = mode ? ST_SCAN : ST_DIRECT;
          end
        end
        ST_SCAN: begin
          // An abort on the same edge as the final step takes this branch
          // too, so only one scan_done pulse is produced.
          if (abort_req || (dwell_q == LAST_DWELL && step_q == LAST_STEP)) begin
            out_d       = INACTIVE;
            step_d      = '0;
            dwell_d     = '0;
            scan_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else if (dwell_q == LAST_DWELL) begin
            // The index is exactly SEL_W bits wide, so it wraps naturally.
            idx_d       = idx_q + 1'b1;
            out_d       = decode(idx_q + 1'b1);
            step_d      = step_q + 1'b1;
            dwell_d     = '0;
            out_valid_d = 1'b1;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        default: begin
          out_d   = INACTIVE;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      out_q       <= INACTIVE;
      out_valid_q <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      scan_done_q <= scan_done_d;
    end
  end

endmodule

// File: tb/tb_decoder_nx2n_scan.sv
// Testbench for decoder_nx2n_scan (SEL_W=3, DWELL=2).
// A second instance with ACTIVE_LOW=1 shares the same inputs.
module tb_decoder_nx2n_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic       mode;
  logic [2:0] sel;
  logic       abort;
  logic       in_ready, out_valid, busy, scan_done;
  logic [7:0] out;
  logic [1:0] state_dbg;
  logic       al_in_ready, al_out_valid, al_busy, al_scan_done;
  logic [7:0] al_out;
  logic [1:0] al_state_dbg;

  // Each entry is {scan_done, out}. One entry is consumed per
  // out_valid or scan_done pulse.
  logic [8:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  decoder_nx2n_scan #(.SEL_W(3), .DWELL(2), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel),
`ifdef DECODER_ABORT_EN
    .abort(abort),
`endif
    .out(out), .out_valid(out_valid), .busy(busy), .scan_done(scan_done),
    .state_dbg(state_dbg)
  );

  decoder_nx2n_scan #(.SEL_W(3), .DWELL(2), .ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(al_in_ready),
    .mode(mode), .sel(sel),
`ifdef DECODER_ABORT_EN
    .abort(abort),
`endif
    .out(al_out), .out_valid(al_out_valid), .busy(al_busy), .scan_done(al_scan_done),
    .state_dbg(al_state_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic done, input logic [7:0] o);
    exp_q.push_back({done, o});
  endtask

  // Presents one command; the DUT accepts it on the next edge (Pa).
  // The task returns at Pa+1.
  task automatic issue(input logic m, input logic [2:0] s);
    tick();
    in_valid = 1'b1;
    mode     = m;
    sel      = s;
    chk("in_ready_issue", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && (out_valid || scan_done)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got done=%0b out=%0h expected no pulse at %0t",
                 scan_done, out, $time);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("sb_pulse", 32'({scan_done, out}), 32'(e));
      end
    end
  end

  // ---------------- stimulus tables ----------------
  logic [7:0] scan5_tab [16] = '{8'h20, 8'h20, 8'h40, 8'h40, 8'h80, 8'h80, 8'h01, 8'h01,
                                 8'h02, 8'h02, 8'h04, 8'h04, 8'h08, 8'h08, 8'h10, 8'h10};
  logic [7:0] frz_tab [19] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h04, 8'h04, 8'h08,
                               8'h08, 8'h10, 8'h10, 8'h20, 8'h20, 8'h40, 8'h40, 8'h80,
                               8'h80, 8'h01, 8'h01};
  logic [7:0] line_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; mode = 1'b0; sel = '0; abort = 1'b0;
    #23;
    // Reset values.
    chk("rst_out", 32'(out), 32'h00);
    chk("rst_out_al", 32'(al_out), 32'hFF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_scan_done", 32'(scan_done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1 chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // 1: DIRECT sweep, back-to-back accepts.
    for (int i = 0; i < 8; i++) begin
      tick();
      in_valid = 1'b1; mode = 1'b0; sel = 3'(i);
      push(1'b0, line_tab[i]);
      chk("sweep_in_ready", 32'(in_ready), 32'd1);
    end
    tick();
    in_valid = 1'b0;
    tick();
    chk("sweep_hold", 32'(out), 32'h80);

    // 2: SCAN from 5. in_valid is held during the scan and must be ignored.
    for (int i = 0; i < 8; i++) push(1'b0, scan5_tab[2*i]);
    push(1'b1, 8'h00);
    issue(1'b1, 3'd5);
    in_valid = 1'b1; mode = 1'b0; sel = 3'd1;
    chk("scan_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("scan5_out", 32'(out), 32'(scan5_tab[k]));
      chk("scan5_busy", 32'(busy), 32'd1);
      if (k == 5) in_valid = 1'b0;
    end
    @(negedge clk);
    chk("scan5_end_out", 32'(out), 32'h00);
    chk("scan5_end_done", 32'(scan_done), 32'd1);
    chk("scan5_end_busy", 32'(busy), 32'd0);
    chk("scan5_end_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("scan5_done_pulse", 32'(scan_done), 32'd0);

    // 3: freeze for 3 cycles on line 02 while dwell=1.
    for (int i = 0; i < 8; i++) push(1'b0, frz_tab[(i == 0) ? 0 : 2*i + 3]);
    push(1'b1, 8'h00);
    issue(1'b1, 3'd1);
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      chk("freeze_out", 32'(out), 32'(frz_tab[k]));
      en = (k >= 1 && k <= 3) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    chk("freeze_end_out", 32'(out), 32'h00);
    chk("freeze_end_done", 32'(scan_done), 32'd1);

    // 4: reset at step 3 (line 08). No scan_done may follow.
    push(1'b0, 8'h01); push(1'b0, 8'h02); push(1'b0, 8'h04); push(1'b0, 8'h08);
    issue(1'b1, 3'd0);
    for (int k = 0; k < 7; k++) @(negedge clk);
    chk("pre_rst_out", 32'(out), 32'h08);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out", 32'(out), 32'h00);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_state", 32'(state_dbg), 32'd0);
    #3 rst = 1'b0;
    tick();
    tick();
    push(1'b0, 8'h40);
    issue(1'b0, 3'd6);
    @(negedge clk);
    chk("post_rst_direct", 32'(out), 32'h40);

    // 5: ACTIVE_LOW instance, DIRECT sel=2.
    push(1'b0, 8'h04);
    issue(1'b0, 3'd2);
    @(negedge clk);
    chk("al_direct", 32'(al_out), 32'hFB);
    chk("al_hi_direct", 32'(out), 32'h04);

`ifdef DECODER_ABORT_EN
    // 6: abort at step 2.
    push(1'b0, 8'h01); push(1'b0, 8'h02); push(1'b0, 8'h04); push(1'b1, 8'h00);
    issue(1'b1, 3'd0);
    for (int k = 0; k < 5; k++) @(negedge clk);
    chk("pre_abort_out", 32'(out), 32'h04);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_out", 32'(out), 32'h00);
    chk("abort_done", 32'(scan_done), 32'd1);
    chk("abort_ready", 32'(in_ready), 32'd1);
`endif

    tick();
    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
